// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the four-digit multiplexed seven-segment driver.
// Holds the segment codes for 0..9 and BLANK (active-low, bit6..bit0 = g..a),
// the digit slot indices, the all-off anode pattern, and the packed BCD time
// payload that is sampled, synchronised and shadowed by seven_seg_scan.
package seven_seg_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned AN_W  = 4;
    localparam int unsigned DIG_W = 4;
    localparam int unsigned IDX_W = 2;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    localparam logic [IDX_W-1:0] DIG_MIN_U = 2'd0;
    localparam logic [IDX_W-1:0] DIG_MIN_T = 2'd1;
    localparam logic [IDX_W-1:0] DIG_HRS_U = 2'd2;
    localparam logic [IDX_W-1:0] DIG_HRS_T = 2'd3;

    localparam logic [AN_W-1:0] AN_OFF = 4'hF;

    // 13-bit BCD time word as presented by the time-setting logic.
    typedef struct packed {
        logic [1:0] hrs_tens;
        logic [3:0] hrs_unit;
        logic [2:0] min_tens;
        logic [3:0] min_unit;
    } time_bcd_t;

endpackage

// File: rtl/seg_decode.sv
// BCD to active-low seven-segment decoder (purely combinational).
// Ports:
//   digit  in  4  BCD value; anything above 9 decodes to blank
//   seg_n  out 7  active-low segments, bit6..bit0 = g..a
module seg_decode
    import seven_seg_pkg::*;
(
    input  logic [DIG_W-1:0] digit,
    output logic [SEG_W-1:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        case (digit)
            4'd0: seg_n = SEG_0;
            4'd1: seg_n = SEG_1;
            4'd2: seg_n = SEG_2;
            4'd3: seg_n = SEG_3;
            4'd4: seg_n = SEG_4;
            4'd5: seg_n = SEG_5;
            4'd6: seg_n = SEG_6;
            4'd7: seg_n = SEG_7;
            4'd8: seg_n = SEG_8;
            4'd9: seg_n = SEG_9;
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment scanner for an HH:MM clock display.
// A prescaler divides clk into digit slots; four slots form a frame. Inputs are
// double-registered and copied into a shadow register only at frame end when
// both samples agree, so the display never tears mid-frame. The decimal point
// on the hours-unit digit blinks with a half-period of BLINK_FRAMES frames.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses a zero hours-tens digit.
// Ports:
//   clk       in  1  system clock, all logic on posedge
//   rst_n     in  1  synchronous active-low reset
//   min_unit  in  4  BCD minutes units
//   min_tens  in  3  BCD minutes tens
//   hrs_unit  in  4  BCD hours units
//   hrs_tens  in  2  BCD hours tens
//   seg_n     out 7  active-low segments g..a, registered
//   an_n      out 4  active-low digit enables, [0] = min_unit, registered
//   dp_n      out 1  active-low decimal point, registered
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       min_unit,
    input  logic [2:0]       min_tens,
    input  logic [3:0]       hrs_unit,
    input  logic [1:0]       hrs_tens,
    output logic [SEG_W-1:0] seg_n,
    output logic [AN_W-1:0]  an_n,
    output logic             dp_n
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [FRM_W-1:0] frame_cnt;
    logic             phase;
    time_bcd_t        in_now, in_q1, in_q2, shadow;

    logic             slot_end_c, frame_end_c, blank_c;
    logic [DIG_W-1:0] digit_c;
    logic [SEG_W-1:0] seg_dec_c, seg_c;
    logic [AN_W-1:0]  an_c;
    logic             dp_c;

    assign in_now      = {hrs_tens, hrs_unit, min_tens, min_unit};
    assign slot_end_c  = (cnt == CNT_LAST);
    assign frame_end_c = slot_end_c && (idx == DIG_HRS_T);
    // First cycle of every slot is dark so the previous digit cannot ghost.
    assign blank_c     = (cnt == '0);

    // Digit mux from the shadow copy, narrow fields zero-extended.
    always_comb begin
        digit_c = shadow.min_unit;
        case (idx)
            DIG_MIN_U: digit_c = shadow.min_unit;
            DIG_MIN_T: digit_c = {1'b0, shadow.min_tens};
            DIG_HRS_U: digit_c = shadow.hrs_unit;
            DIG_HRS_T: digit_c = {2'b00, shadow.hrs_tens};
            default:   digit_c = shadow.min_unit;
        endcase
    end

    seg_decode u_seg_decode (
        .digit (digit_c),
        .seg_n (seg_dec_c)
    );

    // Next output values; registered below so outputs lag state by one clk.
    always_comb begin
        seg_c = seg_dec_c;
        an_c  = blank_c ? AN_OFF : ~(AN_W'(1) << idx);
        dp_c  = !((idx == DIG_HRS_U) && !blank_c && phase);
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx == DIG_HRS_T) && (shadow.hrs_tens == 2'd0)) begin
            an_c  = AN_OFF;
            seg_c = SEG_BLANK;
        end
`endif
    end

    // Scan counters, input synchroniser, shadow load and blink phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            idx       <= DIG_MIN_U;
            frame_cnt <= '0;
            phase     <= 1'b0;
            in_q1     <= '0;
            in_q2     <= '0;
            shadow    <= '0;
        end else begin
            cnt   <= slot_end_c ? '0 : cnt + 1'b1;
            in_q1 <= in_now;
            in_q2 <= in_q1;
            if (slot_end_c) begin
                idx <= idx + 1'b1;
            end
            if (frame_end_c) begin
                // Only accept a value seen identically on two consecutive cycles.
                if (in_q1 == in_q2) begin
                    shadow <= in_q1;
                end
                if (frame_cnt == FRM_LAST) begin
                    frame_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_n <= SEG_BLANK;
            an_n  <= AN_OFF;
            dp_n  <= 1'b1;
        end else begin
            seg_n <= seg_c;
            an_n  <= an_c;
            dp_n  <= dp_c;
        end
    end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles per digit slot (1 kHz digit rate at 50 MHz); legal range >= 4.
REQ-002 Parameter BLINK_FRAMES, default 125: frames per half-period of the decimal-point blink.
REQ-003 clk  in  1  single system clock; all logic on posedge clk.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 min_unit  in  4  BCD minutes units, driven by the time-setting logic.
REQ-006 min_tens  in  3  BCD minutes tens.
REQ-007 hrs_unit  in  4  BCD hours units.
REQ-008 hrs_tens  in  2  BCD hours tens.
REQ-009 seg_n  out  7  active-low segments, bit6..bit0 = g..a, registered.
REQ-010 an_n  out  4  active-low digit enables, an_n[0] = min_unit (rightmost) ... an_n[3] = hrs_tens, registered.
REQ-011 dp_n  out  1  active-low decimal point, registered.

Function
REQ-012 Prescaler cnt counts 0..SCAN_DIV-1 and wraps; at cnt==SCAN_DIV-1, digit index idx advances 0->1->2->3->0.
REQ-013 idx 0/1/2/3 selects min_unit/min_tens/hrs_unit/hrs_tens from the shadow registers; frame = 4 slots.
REQ-014 Outputs lag internal state by exactly one clk: values at cycle t+1 derive from cnt/idx/shadow at cycle t.
REQ-015 Blanking: in the cycle after cnt==0, an_n = 4'hF (anti-ghosting); otherwise exactly one an_n bit low, at idx.
REQ-016 Inputs are registered twice (in_q1, in_q2); shadow registers load in_q1 only at frame end (cnt==SCAN_DIV-1 and idx==3) and only if in_q1==in_q2 across all 13 bits; otherwise shadow holds for another frame.
REQ-017 Segment codes (hex, seg_n) for 0..9: 40,79,24,30,19,12,02,78,00,10; any value >9 drives 7F (blank).
REQ-018 Narrow inputs are zero-extended to 4 bits before decoding.
REQ-019 Blink phase toggles each time BLINK_FRAMES frames have completed; dp_n = 0 only while idx==2, the digit is not blanked, and phase==1; otherwise 1.
REQ-020 Input changes mid-frame do not alter displayed digits before the next qualifying frame end.

Reset
REQ-021 While rst_n==0 at a posedge: cnt=0, idx=0, frame counter=0, phase=0, in_q1/in_q2/shadow=0, seg_n=7'h7F, an_n=4'hF, dp_n=1.
REQ-022 Reset asserted mid-slot or mid-frame takes effect on the next posedge and overrides all other updates; scanning restarts at idx 0 on the first cycle after release.

Configuration
REQ-023 Macro LEADING_ZERO_BLANK_EN defined: when shadow hrs_tens==0 and idx==3, an_n[3] stays 1 and seg_n=7'h7F for that slot.
REQ-024 Macro LEADING_ZERO_BLANK_EN undefined: hrs_tens==0 displays code 40 like any other digit.

Structure
REQ-025 Package seven_seg_pkg holds: segment code constants for 0..9 and BLANK (7F), digit index constants DIG_MIN_U..DIG_HRS_T, and AN_OFF (4'hF).
REQ-026 One combinational sub-module seg_decode (4-bit BCD in, 7-bit seg_n out) per REQ-017, instantiated once on the muxed digit.

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-027 Reset held 3 cycles, then released with inputs 0 -> an_n=F, seg_n=7F, dp_n=1 during reset; an_n cycles E,D,B,7 with one F blanking cycle per slot; each slot's seg_n=40 (slot 3 blank under LEADING_ZERO_BLANK_EN).
REQ-028 Inputs 1/2/3/4 (hrs_tens..min_unit), held stable -> from the second frame onward slots 0..3 show 19,30,24,79.
REQ-029 min_unit toggled 5->6 mid-frame -> slot 0 stays 12 until the frame end following two stable samples, then 02.
REQ-030 min_unit driven to 4'hA -> slot 0 seg_n=7F with an_n[0] low; other slots unaffected.
REQ-031 Run 8 frames -> dp_n low only in slot 2 non-blank cycles, during frames 3-4 and 7-8 (phase toggles every 2 frames).
REQ-032 rst_n pulsed low at idx 2, cnt 2 -> next cycle outputs at reset values; scan resumes at idx 0, phase 0, shadow 0.
